fwd_hazard_ctrl: RTL and testbench

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/fwd_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB destinations, detects load-use
// hazards (one-cycle stall) and registers operand-forwarding selects for EX.
module fwd_hazard_ctrl #(
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regdst,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            flush,
    output logic            stall,
    output logic [REGW-1:0] ex_wreg,
    output logic [REGW-1:0] mem_wreg,
    output logic [REGW-1:0] wb_wreg,
    output logic            ex_we,
    output logic            mem_we,
    output logic            wb_we,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // ID-stage decode
    logic [REGW-1:0] id_dest;
    logic            id_we;
    logic            id_ld;
    logic            load_use;
    logic            capture;
    logic [1:0]      fwd_a_id;
    logic [1:0]      fwd_b_id;

    // Stage state
    logic [REGW-1:0] ex_wreg_q,  ex_wreg_d;
    logic            ex_we_q,    ex_we_d;
    logic            ex_ld_q,    ex_ld_d;
    logic [REGW-1:0] mem_wreg_q, mem_wreg_d;
    logic            mem_we_q,   mem_we_d;
    logic [REGW-1:0] wb_wreg_q,  wb_wreg_d;
    logic            wb_we_q,    wb_we_d;
    logic [1:0]      fwd_a_q,    fwd_a_d;
    logic [1:0]      fwd_b_q,    fwd_b_d;

    // Producer one stage ahead becomes the MEM result; two ahead the WB result.
    function automatic logic [1:0] fwd_code(
        input logic [REGW-1:0] src,
        input logic [REGW-1:0] ex_r,
        input logic            ex_w,
        input logic [REGW-1:0] mem_r,
        input logic            mem_w
    );
        logic [1:0] code;
        code = FWD_RF;
        if (src != '0) begin
            if (ex_w && (ex_r == src)) begin
                code = FWD_MEM;
            end else if (mem_w && (mem_r == src)) begin
                code = FWD_WB;
            end
        end
        return code;
    endfunction

    always_comb begin
        id_dest = id_regdst ? id_rd : id_rt;
        id_we   = id_valid & id_regwrite & (id_dest != '0);
        id_ld   = id_valid & id_memread;
    end

    // A load in EX cannot supply its data until after MEM, so the consumer waits one cycle.
    always_comb begin
        load_use = ex_ld_q & ex_we_q & id_valid &
                   ((id_rs == ex_wreg_q) | (id_rt == ex_wreg_q));
        stall    = load_use & ~flush & ~rst;
        capture  = ~load_use & ~flush;
    end

    always_comb begin
        fwd_a_id = fwd_code(id_rs, ex_wreg_q, ex_we_q, mem_wreg_q, mem_we_q);
        fwd_b_id = fwd_code(id_rt, ex_wreg_q, ex_we_q, mem_wreg_q, mem_we_q);
    end

    // Next-state: EX takes ID or a bubble; MEM and WB always advance.
    always_comb begin
        ex_wreg_d  = '0;
        ex_we_d    = 1'b0;
        ex_ld_d    = 1'b0;
        fwd_a_d    = FWD_RF;
        fwd_b_d    = FWD_RF;
        mem_wreg_d = ex_wreg_q;
        mem_we_d   = ex_we_q;
        wb_wreg_d  = mem_wreg_q;
        wb_we_d    = mem_we_q;
        if (capture) begin
            ex_wreg_d = id_dest;
            ex_we_d   = id_we;
            ex_ld_d   = id_ld;
            fwd_a_d   = fwd_a_id;
            fwd_b_d   = fwd_b_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_wreg_q  <= '0;
            ex_we_q    <= 1'b0;
            ex_ld_q    <= 1'b0;
            mem_wreg_q <= '0;
            mem_we_q   <= 1'b0;
            wb_wreg_q  <= '0;
            wb_we_q    <= 1'b0;
            fwd_a_q    <= FWD_RF;
            fwd_b_q    <= FWD_RF;
        end else begin
            ex_wreg_q  <= ex_wreg_d;
            ex_we_q    <= ex_we_d;
            ex_ld_q    <= ex_ld_d;
            mem_wreg_q <= mem_wreg_d;
            mem_we_q   <= mem_we_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_we_q    <= wb_we_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
        end
    end

    assign ex_wreg  = ex_wreg_q;
    assign mem_wreg = mem_wreg_q;
    assign wb_wreg  = wb_wreg_q;
    assign ex_we    = ex_we_q;
    assign mem_we   = mem_we_q;
    assign wb_we    = wb_we_q;
    assign fwd_a    = fwd_a_q;
    assign fwd_b    = fwd_b_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: random and directed instruction streams
// checked against a stage-list reference model.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_regdst, id_regwrite, id_memread, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       stall;
    logic [4:0] ex_wreg, mem_wreg, wb_wreg;
    logic       ex_we, mem_we, wb_we;
    logic [1:0] fwd_a, fwd_b;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REGW(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall(stall),
        .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    typedef struct packed {
        logic       stall;
        logic [4:0] exw, memw, wbw;
        logic       exwe, memwe, wbwe;
        logic [1:0] fa, fb;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
    logic [4:0] m_dest[3];
    bit         m_we[3];
    bit         m_ld[3];
    logic [1:0] m_fa, m_fb;
    bit         last_stall;

    logic       c_v, c_dst, c_rw, c_mr;
    logic [4:0] c_rs, c_rt, c_rd;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_dest[k] = 5'd0; m_we[k] = 1'b0; m_ld[k] = 1'b0;
        end
        m_fa = 2'b00; m_fb = 2'b00; last_stall = 1'b0;
    endtask

    // Which later stage holds the newest writer of src: EX now -> MEM result (10), MEM now -> WB result (01).
    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        for (int k = 0; k < 2; k++)
            if (m_we[k] && m_dest[k] == src) return (k == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic model_step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic dst, input logic rw,
                              input logic mr, input logic fl);
        logic [4:0] dest;
        bit         we, hz, s, take;
        logic [1:0] fa, fb;
        exp_t       e;
        dest = dst ? rd : rt;
        we   = v && rw && (dest != 5'd0);
        hz   = v && m_ld[0] && m_we[0] && (rs == m_dest[0] || rt == m_dest[0]);
        s    = hz && !fl;
        take = !hz && !fl;
        fa   = take ? model_fwd(rs) : 2'b00;
        fb   = take ? model_fwd(rt) : 2'b00;
        for (int k = 2; k > 0; k--) begin
            m_dest[k] = m_dest[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1];
        end
        m_dest[0] = take ? dest : 5'd0;
        m_we[0]   = take && we;
        m_ld[0]   = take && v && mr;
        m_fa = fa; m_fb = fb; last_stall = s;
        e.stall = s;
        e.exw = m_dest[0]; e.memw = m_dest[1]; e.wbw = m_dest[2];
        e.exwe = m_we[0];  e.memwe = m_we[1];  e.wbwe = m_we[2];
        e.fa = m_fa; e.fb = m_fb;
        sbq.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic dst, input logic rw,
                         input logic mr, input logic fl);
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_regdst = dst; id_regwrite = rw; id_memread = mr; flush = fl;
        model_step(v, rs, rt, rd, dst, rw, mr, fl);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 8'(stall), 8'd0);
        chk({tag, "_wregs"}, 8'(ex_wreg | mem_wreg | wb_wreg), 8'd0);
        chk({tag, "_wes"},   8'({ex_we, mem_we, wb_we}), 8'd0);
        chk({tag, "_fwd"},   8'({fwd_a, fwd_b}), 8'd0);
    endtask

    // Monitor: stall checked mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sbq.size() != 0) begin
                e = sbq[0];
                chk("stall", 8'(stall), 8'(e.stall));
                @(posedge clk);
                #1;
                chk("ex_wreg",  8'(ex_wreg),  8'(e.exw));
                chk("mem_wreg", 8'(mem_wreg), 8'(e.memw));
                chk("wb_wreg",  8'(wb_wreg),  8'(e.wbw));
                chk("we_vec",   8'({ex_we, mem_we, wb_we}), 8'({e.exwe, e.memwe, e.wbwe}));
                chk("fwd_a",    8'(fwd_a), 8'(e.fa));
                chk("fwd_b",    8'(fwd_b), 8'(e.fb));
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_regdst = 0; id_regwrite = 0; id_memread = 0; flush = 0;
        model_reset();
        #2;
        chk_all_zero("reset");
        @(posedge clk); #2; rst = 1'b0;

        // EX->EX then MEM->EX forwarding
        drive(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0);
        drive(1, 5'd3, 5'd6, 5'd7, 1, 1, 0, 0);
        @(posedge clk); #2; chk("d018_fwd_a", 8'(fwd_a), 8'b10);
        drive(1, 5'd8, 5'd3, 5'd9, 1, 1, 0, 0);
        @(posedge clk); #2; chk("d018_fwd_b", 8'(fwd_b), 8'b01);

        // Load-use: one stall cycle, then WB forward
        nops(3);
        drive(1, 5'd0, 5'd5, 5'd0, 0, 1, 1, 0);
        drive(1, 5'd5, 5'd6, 5'd7, 1, 1, 0, 0);
        #3; chk("d019_stall1", 8'(stall), 8'd1);
        @(posedge clk); #2; chk("d019_bubble", 8'(ex_we), 8'd0);
        drive(1, 5'd5, 5'd6, 5'd7, 1, 1, 0, 0);
        #3; chk("d019_stall2", 8'(stall), 8'd0);
        @(posedge clk); #2;
        chk("d019_fwd_a", 8'(fwd_a), 8'b01);
        chk("d019_wb", 8'({wb_wreg, wb_we}), 8'({5'd5, 1'b1}));

        // Register 0 never tracked, even for a load
        nops(3);
        drive(1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
        @(posedge clk); #2; chk("d020_ex_we", 8'(ex_we), 8'd0);
        drive(1, 5'd0, 5'd0, 5'd7, 1, 1, 0, 0);
        #3; chk("d020_stall", 8'(stall), 8'd0);
        @(posedge clk); #2; chk("d020_fwd_a", 8'(fwd_a), 8'b00);

        // Flush overrides a pending load-use hazard
        nops(3);
        drive(1, 5'd0, 5'd5, 5'd0, 0, 1, 1, 0);
        drive(1, 5'd5, 5'd6, 5'd7, 1, 1, 0, 1);
        #3; chk("d021_stall", 8'(stall), 8'd0);
        @(posedge clk); #2; chk("d021_bubble", 8'({ex_wreg, ex_we}), 8'd0);
        nops(1);
        @(posedge clk); #2; chk("d021_mem_we", 8'(mem_we), 8'd0);

        // Double hit: nearer stage wins
        nops(3);
        drive(1, 5'd1, 5'd2, 5'd4, 1, 1, 0, 0);
        drive(1, 5'd1, 5'd2, 5'd4, 1, 1, 0, 0);
        drive(1, 5'd4, 5'd4, 5'd7, 1, 1, 0, 0);
        @(posedge clk); #2; chk("d022_fwd", 8'({fwd_a, fwd_b}), 8'b1010);

        // Reset asserted in the middle of a stall
        nops(3);
        drive(1, 5'd0, 5'd5, 5'd0, 0, 1, 1, 0);
        @(negedge clk);
        id_valid = 1; id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd7;
        id_regdst = 1; id_regwrite = 1; id_memread = 0; flush = 0;
        #3; chk("d017_pre_stall", 8'(stall), 8'd1);
        #1; rst = 1'b1;
        #1; chk_all_zero("midrst");
        model_reset();
        @(posedge clk); #2; rst = 1'b0;
        drive(1, 5'd5, 5'd6, 5'd7, 1, 1, 0, 0);
        #3; chk("d016_post_stall", 8'(stall), 8'd0);

        // Random stream; upstream holds the instruction while stalled
        for (int n = 0; n < 1500; n++) begin
            if (!last_stall) begin
                c_v   = ($urandom_range(0, 7) != 0);
                c_rs  = 5'($urandom_range(0, 7));
                c_rt  = 5'($urandom_range(0, 7));
                c_rd  = 5'($urandom_range(0, 7));
                c_dst = 1'($urandom_range(0, 1));
                c_rw  = ($urandom_range(0, 3) != 0);
                c_mr  = c_rw && ($urandom_range(0, 2) == 0);
            end
            drive(c_v, c_rs, c_rt, c_rd, c_dst, c_rw, c_mr, 1'($urandom_range(0, 15) == 0));
        end

        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
        #3;
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
